sn76489_bus_writer: RTL and testbench

Host-side initiator for the SN76489 PSG write bus; drives the d/nWE/nCE strobe protocol that sn76489_cpu_interface decodes.
- Accepts logical register-write commands via valid/ready.
- Encodes each command into one latch byte (attenuation/noise) or a latch byte plus a data byte (tone frequency).
- Paces every byte on the responder's ready output.
- Sits between the emulator's I/O port decoder (Z80 OUT to PSG) and the PSG.

---
 rtl/sn76489_pkg.sv | 48 ++++
 rtl/sn76489_bus_writer.sv | 173 +++++++++++++++++
 tb/tb_sn76489_bus_writer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sn76489_pkg.sv
// -----------------------------------------------------------------------------
// sn76489_pkg
// Definitions shared by the SN76489 PSG write-bus initiator and responder:
//   - 3-bit bus register codes (tone frequency, noise control, attenuation)
//   - writer state encoding
//   - helpers that classify register codes and build bus bytes
// -----------------------------------------------------------------------------
package sn76489_pkg;

    // Bus register codes. The three tone registers are not in channel order.
    localparam logic [2:0] REG_FREQ1      = 3'd0;
    localparam logic [2:0] REG_FREQ3      = 3'd1;
    localparam logic [2:0] REG_FREQ2      = 3'd2;
    localparam logic [2:0] REG_NOISE_CTRL = 3'd3;
    localparam logic [2:0] REG_ATT1       = 3'd4;
    localparam logic [2:0] REG_ATT3       = 3'd5;
    localparam logic [2:0] REG_ATT2       = 3'd6;
    localparam logic [2:0] REG_NOISE_ATT  = 3'd7;

    typedef enum logic [2:0] {
        WR_IDLE    = 3'd0,
        WR_SETUP   = 3'd1,
        WR_STROBE  = 3'd2,
        WR_HOLD    = 3'd3,
        WR_RELEASE = 3'd4,
        WR_ABORT   = 3'd5
    } writer_state_e;

    // Tone registers carry 10 bits and need a latch byte plus a data byte.
    function automatic logic is_freq_reg(input logic [2:0] code);
        return (code == REG_FREQ1) || (code == REG_FREQ2) || (code == REG_FREQ3);
    endfunction

    // First byte of any write; bit 0 set marks it as a latch byte.
    function automatic logic [7:0] latch_byte(input logic [2:0] code,
                                              input logic [9:0] value);
        if (is_freq_reg(code)) begin
            return {value[9:6], code, 1'b1};
        end
        return {value[3:0], code, 1'b1};
    endfunction

    // Second byte of a tone write: low six frequency bits, latch flag clear.
    function automatic logic [7:0] data_byte(input logic [9:0] value);
        return {value[5:0], 2'b00};
    endfunction

endpackage

// File: rtl/sn76489_bus_writer.sv
// -----------------------------------------------------------------------------
// sn76489_bus_writer
// Host-side initiator for the SN76489 PSG write bus. Takes logical register
// writes over valid/ready, encodes them into one or two bus bytes and strobes
// each byte with nCE/nWE, pacing on the responder's ready handshake.
//
// Ports
//   clock        in   system clock, all state on rising edge
//   reset        in   asynchronous active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  writer idle and able to accept a command
//   cmd_reg      in   3-bit bus register code
//   cmd_value    in   tone: [9:0]; other registers: [3:0]
//   d            out  PSG data bus (registered)
//   nWE          out  active-low write strobe (registered)
//   nCE          out  active-low chip enable (registered)
//   ready        in   responder ready (high when idle or finished)
//   busy         out  writer not idle
//   timeout_err  out  one-cycle pulse when a byte is aborted
// -----------------------------------------------------------------------------
module sn76489_bus_writer
    import sn76489_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_reg,
    input  logic [9:0] cmd_value,
    output logic [7:0] d,
    output logic       nWE,
    output logic       nCE,
    input  logic       ready,
    output logic       busy,
    output logic       timeout_err
);

    // One counter serves both the strobe/hold timeout and the release gap,
    // so it must be wide enough for whichever limit is larger.
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_EFF) ? TIMEOUT_CYCLES : GAP_EFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_EFF - 1);

    writer_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       d_q, d_d;
    logic [7:0]       byte1_q, byte1_d;
    logic             pending_q, pending_d;
    logic             nce_q, nce_d;
    logic             nwe_q, nwe_d;
    logic             timeout_err_q, timeout_err_d;

    logic             accept;
    logic             timed_out;
    logic [CNT_W-1:0] cnt_sat;
    logic             strobing;

    assign cmd_ready = (state_q == WR_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign timed_out = (cnt_q == TIMEOUT_LIM);
    assign cnt_sat   = timed_out ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        byte1_d   = byte1_q;
        pending_d = pending_q;

        unique case (state_q)
            WR_IDLE: begin
                if (accept) begin
                    state_d   = WR_SETUP;
                    d_d       = latch_byte(cmd_reg, cmd_value);
                    byte1_d   = data_byte(cmd_value);
                    pending_d = is_freq_reg(cmd_reg);
                end
            end
            WR_SETUP: begin
                state_d = WR_STROBE;
                cnt_d   = '0;
            end
            WR_STROBE: begin
                // A ready change wins over a timeout landing on the same cycle.
                if (!ready) begin
                    state_d = WR_HOLD;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    state_d = WR_ABORT;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            WR_HOLD: begin
                if (ready) begin
                    state_d = WR_RELEASE;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    state_d = WR_ABORT;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            WR_RELEASE: begin
                if (cnt_q >= GAP_LAST) begin
                    if (pending_q) begin
                        state_d   = WR_SETUP;
                        d_d       = byte1_q;
                        pending_d = 1'b0;
                    end else begin
                        state_d = WR_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_ABORT: begin
                state_d   = WR_IDLE;
                pending_d = 1'b0;
            end
            default: begin
                state_d   = WR_IDLE;
                pending_d = 1'b0;
            end
        endcase

        // Bus strobes are derived from the next state so the registered
        // outputs line up exactly with the state they belong to.
        strobing      = (state_d == WR_STROBE) || (state_d == WR_HOLD);
        nce_d         = !strobing;
        nwe_d         = !strobing;
        timeout_err_d = (state_d == WR_ABORT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values computed before the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= WR_IDLE;
            cnt_q         <= '0;
            d_q           <= 8'h00;
            byte1_q       <= 8'h00;
            pending_q     <= 1'b0;
            nce_q         <= 1'b1;
            nwe_q         <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            d_q           <= d_d;
            byte1_q       <= byte1_d;
            pending_q     <= pending_d;
            nce_q         <= nce_d;
            nwe_q         <= nwe_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign d           = d_q;
    assign nCE         = nce_q;
    assign nWE         = nwe_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != WR_IDLE);

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// -----------------------------------------------------------------------------
// tb_sn76489_bus_writer
// Directed bench for sn76489_bus_writer. A small responder model answers the
// nCE/nWE strobes with the ready handshake and decodes the bytes into PSG
// registers. Expected bus bytes are queued when a command is issued; a bus
// monitor pops and compares them at every falling nCE.
// -----------------------------------------------------------------------------
module tb_sn76489_bus_writer;
    import sn76489_pkg::*;

    localparam int TO_CYCLES = 16;
    localparam int BUSY_N    = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_reg = 3'd0;
    logic [9:0] cmd_value = 10'd0;
    logic [7:0] d;
    logic       nWE;
    logic       nCE;
    logic       ready;
    logic       busy;
    logic       timeout_err;

    // 0: responder drives ready, 1: ready tied high, 2: ready forced low
    logic [1:0] ready_mode = 2'd0;

    int errors = 0;
    int checks = 0;

    sn76489_bus_writer #(.TIMEOUT_CYCLES(TO_CYCLES), .GAP_CYCLES(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_reg     (cmd_reg),
        .cmd_value   (cmd_value),
        .d           (d),
        .nWE         (nWE),
        .nCE         (nCE),
        .ready       (ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- responder model ----------------
    typedef enum logic [1:0] {R_IDLE, R_BUSY, R_FIN} rstate_e;
    rstate_e    r_state    = R_IDLE;
    int         r_cnt      = 0;
    logic       resp_ready = 1'b1;
    logic [7:0] r_byte     = 8'h00;
    logic [2:0] r_latch    = 3'd0;
    logic [9:0] tone [0:7] = '{default: 10'd0};
    logic [3:0] regv [0:7] = '{default: 4'd0};

    assign ready = (ready_mode == 2'd1) ? 1'b1 :
                   (ready_mode == 2'd2) ? 1'b0 : resp_ready;

    // Registers commit only when the strobe is released after the responder
    // finished; a strobe dropped early discards the byte.
    always @(posedge clock) begin
        case (r_state)
            R_IDLE: if (!nCE && !nWE) begin
                r_byte     <= d;
                r_cnt      <= BUSY_N;
                resp_ready <= 1'b0;
                r_state    <= R_BUSY;
            end
            R_BUSY: if (nCE) begin
                resp_ready <= 1'b1;
                r_state    <= R_IDLE;
            end else if (r_cnt == 0) begin
                resp_ready <= 1'b1;
                r_state    <= R_FIN;
            end else begin
                r_cnt <= r_cnt - 1;
            end
            R_FIN: if (nCE) begin
                if (r_byte[0]) begin
                    r_latch <= r_byte[3:1];
                    if (is_freq_reg(r_byte[3:1])) tone[r_byte[3:1]][9:6] <= r_byte[7:4];
                    else regv[r_byte[3:1]] <= r_byte[7:4];
                end else begin
                    tone[r_latch][5:0] <= r_byte[7:2];
                end
                r_state <= R_IDLE;
            end
            default: r_state <= R_IDLE;
        endcase
    end

    // ---------------- bus monitor / scoreboard ----------------
    logic [7:0] exp_q [$];
    logic       prev_nce     = 1'b1;
    logic [7:0] d_start      = 8'h00;
    logic       d_changed    = 1'b0;
    int         low_len      = 0;
    int         high_len     = 0;
    int         last_low_len = 0;
    int         last_gap     = 0;
    int         strobe_count = 0;
    int         to_cycles    = 0;
    int         idle_len     = 0;
    int         last_idle    = 0;

    always @(negedge clock) begin
        if (prev_nce && !nCE) begin
            strobe_count++;
            last_gap  = high_len;
            low_len   = 1;
            d_start   = d;
            d_changed = 1'b0;
            if (exp_q.size() > 0) begin
                check("strobe_d", 32'(d), 32'(exp_q.pop_front()));
            end else begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: d=%02h with no byte queued", d);
            end
        end else if (!nCE) begin
            low_len++;
            if (d !== d_start) d_changed = 1'b1;
        end else if (!prev_nce && nCE) begin
            last_low_len = low_len;
            high_len     = 1;
            check("d_stable_while_strobed", 32'(d_changed), 32'd0);
        end else begin
            high_len++;
        end
        prev_nce = nCE;

        if (timeout_err) to_cycles++;

        if (!busy) idle_len++;
        else if (idle_len > 0) begin
            last_idle = idle_len;
            idle_len  = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [2:0] r, input logic [9:0] v);
        int n;
        n = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_reg   = r;
        cmd_value = v;
        while (!cmd_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles", cmd_ready, n);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(output int rdy_hi);
        int n;
        n      = 0;
        rdy_hi = 0;
        @(negedge clock);
        while (busy && n < 2000) begin
            if (cmd_ready) rdy_hi++;
            @(negedge clock);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles", busy, n);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_timeout_pulse(input string name);
        int n;
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(timeout_err), 32'd1);
    endtask

    task automatic wait_hold(input string name);
        int n;
        n = 0;
        @(negedge clock);
        while (!(!nCE && !resp_ready) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(!nCE && !resp_ready), 32'd1);
        @(negedge clock);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rdy_hi;
        int sc0;
        int to0;
        logic [9:0] freq3_before;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_nCE", 32'(nCE), 32'd1);
        check("rst_nWE", 32'(nWE), 32'd1);
        check("rst_d", 32'(d), 32'h00);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // ATT1 = 4'hA: single byte 0xA9
        sc0 = strobe_count;
        to0 = to_cycles;
        exp_q.push_back(8'hA9);
        send(REG_ATT1, 10'h00A);
        cmd_valid = 1'b0;
        wait_idle(rdy_hi);
        check("att1_strobes", 32'(strobe_count - sc0), 32'd1);
        check("att1_reg", 32'(regv[4]), 32'hA);
        check("att1_busy_low", 32'(busy), 32'd0);
        check("att1_no_timeout", 32'(to_cycles - to0), 32'd0);

        // FREQ2 = 10'h2B7: bytes 0xA5 then 0xDC
        sc0 = strobe_count;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hDC);
        send(REG_FREQ2, 10'h2B7);
        cmd_valid = 1'b0;
        wait_idle(rdy_hi);
        check("freq2_strobes", 32'(strobe_count - sc0), 32'd2);
        check("freq2_gap_ge1", 32'(last_gap >= 1), 32'd1);
        check("freq2_cmd_ready_low", 32'(rdy_hi), 32'd0);
        check("freq2_reg", 32'(tone[2]), 32'h2B7);

        // Back-to-back: FREQ1 = 3FF, then NOISE_CTRL = 4'b1010 with valid held
        sc0 = strobe_count;
        exp_q.push_back(8'hF1);
        exp_q.push_back(8'hFC);
        exp_q.push_back(8'hA7);
        send(REG_FREQ1, 10'h3FF);
        send(REG_NOISE_CTRL, 10'h00A);
        cmd_valid = 1'b0;
        @(negedge clock);
        #1;
        check("b2b_idle_cycles", 32'(last_idle), 32'd1);
        wait_idle(rdy_hi);
        check("b2b_strobes", 32'(strobe_count - sc0), 32'd3);
        check("b2b_freq1", 32'(tone[0]), 32'h3FF);
        check("b2b_noise_feed", 32'(regv[3][3:2]), 32'h2);
        check("b2b_noise_fb", 32'(regv[3][1]), 32'd1);

        // Dead bus: ready tied high, ATT2 = 5 -> 0x5D, abort after 17 cycles low
        ready_mode = 2'd1;
        to0 = to_cycles;
        exp_q.push_back(8'h5D);
        send(REG_ATT2, 10'h005);
        cmd_valid = 1'b0;
        wait_timeout_pulse("dead_timeout_seen");
        @(negedge clock);
        check("dead_low_len", 32'(last_low_len), 32'd17);
        check("dead_pulse_width", 32'(to_cycles - to0), 32'd1);
        check("dead_nCE", 32'(nCE), 32'd1);
        check("dead_nWE", 32'(nWE), 32'd1);
        check("dead_busy", 32'(busy), 32'd0);
        check("dead_cmd_ready", 32'(cmd_ready), 32'd1);
        ready_mode = 2'd0;
        repeat (20) @(negedge clock);

        // Async reset during HOLD of FREQ3 byte0 (0x155 -> 0x53)
        freq3_before = tone[1];
        sc0 = strobe_count;
        to0 = to_cycles;
        exp_q.push_back(8'h53);
        send(REG_FREQ3, 10'h155);
        cmd_valid = 1'b0;
        wait_hold("rst_mid_reach_hold");
        #2 reset = 1'b1;
        #1;
        check("rst_mid_nCE", 32'(nCE), 32'd1);
        check("rst_mid_nWE", 32'(nWE), 32'd1);
        check("rst_mid_d", 32'(d), 32'h00);
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        check("rst_mid_strobes", 32'(strobe_count - sc0), 32'd1);
        check("rst_mid_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rst_mid_freq3", 32'(tone[1]), 32'(freq3_before));
        check("rst_mid_no_timeout", 32'(to_cycles - to0), 32'd0);

        // Stuck-low ready after HOLD entry: ATT3 = 3 -> 0x3B
        to0 = to_cycles;
        exp_q.push_back(8'h3B);
        send(REG_ATT3, 10'h003);
        cmd_valid = 1'b0;
        wait_hold("stuck_reach_hold");
        ready_mode = 2'd2;
        wait_timeout_pulse("stuck_timeout_seen");
        @(negedge clock);
        check("stuck_low_len", 32'(last_low_len), 32'd19);
        check("stuck_pulse_width", 32'(to_cycles - to0), 32'd1);
        check("stuck_nCE", 32'(nCE), 32'd1);
        check("stuck_busy", 32'(busy), 32'd0);
        ready_mode = 2'd0;
        repeat (20) @(negedge clock);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
